// File: rtl/stage_execute.sv
// Vector execute stage: single-cycle lane-parallel ALU for ops 0-6, and a
// lane-serial multiplier (one lane per cycle) that stalls upstream while busy.
module stage_execute #(
  parameter int vecSize      = 4,
  parameter int registerSize = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   valid_in,
  input  logic [2:0]                             aluOp,
  input  logic [vecSize-1:0][registerSize-1:0]   srcA,
  input  logic [vecSize-1:0][registerSize-1:0]   srcB,
  input  logic [registerSize-1:0]                imm,
  input  logic [registerSize-1:0]                address,
  input  logic                                   writeEnable_in,
  input  logic [1:0]                             writeRegFrom_in,
  input  logic                                   flush,
  output logic                                   stall,
  output logic                                   valid_out,
  output logic [vecSize-1:0][registerSize-1:0]   aluResult,
  output logic [vecSize-1:0][registerSize-1:0]   writeData,
  output logic [registerSize-1:0]                address_out,
  output logic [registerSize-1:0]                imm_out,
  output logic                                   writeEnable_out,
  output logic [1:0]                             writeRegFrom_out
);

  localparam int SHW = (registerSize > 1) ? $clog2(registerSize) : 1;
  localparam int CW  = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                               r_state, w_state_next;
  logic [CW-1:0]                        r_cnt;
  logic [vecSize-1:0][registerSize-1:0] r_acc, w_acc_next;
  logic [vecSize-1:0][registerSize-1:0] r_op_a, r_op_b;
  logic [registerSize-1:0]              r_imm, r_addr;
  logic                                 r_we;
  logic [1:0]                           r_wrf;
  logic [vecSize-1:0][registerSize-1:0] w_alu;
  logic                                 w_accept_alu, w_accept_mul, w_done, w_last;

  function automatic logic [registerSize-1:0] alu_lane(
    input logic [2:0]              op,
    input logic [registerSize-1:0] a,
    input logic [registerSize-1:0] b
  );
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[SHW-1:0];
      3'd6:    return a >> b[SHW-1:0];
      default: return a * b;
    endcase
  endfunction

  assign stall  = (r_state == BUSY);
  assign w_last = (r_cnt == CW'(vecSize - 1));

  always_comb begin
    for (int i = 0; i < vecSize; i++) w_alu[i] = alu_lane(aluOp, srcA[i], srcB[i]);
  end

  always_comb begin
    w_acc_next        = r_acc;
    w_acc_next[r_cnt] = alu_lane(OP_MUL, r_op_a[r_cnt], r_op_b[r_cnt]);
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept_alu = 1'b0;
    w_accept_mul = 1'b0;
    w_done       = 1'b0;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (valid_in) begin
          if (aluOp == OP_MUL) begin
            w_state_next = BUSY;
            w_accept_mul = 1'b1;
          end else begin
            w_accept_alu = 1'b1;
          end
        end
        BUSY: if (w_last) begin
          w_state_next = IDLE;
          w_done       = 1'b1;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the accumulator and operand copies are reset too, so an abandoned
  // multiply leaves no stale lanes behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt            <= '0;
      r_acc            <= '0;
      r_op_a           <= '0;
      r_op_b           <= '0;
      r_imm            <= '0;
      r_addr           <= '0;
      r_we             <= 1'b0;
      r_wrf            <= '0;
      valid_out        <= 1'b0;
      writeEnable_out  <= 1'b0;
      aluResult        <= '0;
      writeData        <= '0;
      address_out      <= '0;
      imm_out          <= '0;
      writeRegFrom_out <= '0;
    end else begin
      valid_out       <= 1'b0;
      writeEnable_out <= 1'b0;
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept_alu) begin
        aluResult        <= w_alu;
        writeData        <= srcB;
        address_out      <= address;
        imm_out          <= imm;
        writeRegFrom_out <= writeRegFrom_in;
        valid_out        <= 1'b1;
        writeEnable_out  <= writeEnable_in;
      end else if (w_accept_mul) begin
        r_op_a <= srcA;
        r_op_b <= srcB;
        r_imm  <= imm;
        r_addr <= address;
        r_we   <= writeEnable_in;
        r_wrf  <= writeRegFrom_in;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == BUSY) begin
        r_acc <= w_acc_next;
        if (w_done) begin
          r_cnt            <= '0;
          aluResult        <= w_acc_next;
          writeData        <= r_op_b;
          address_out      <= r_addr;
          imm_out          <= r_imm;
          writeRegFrom_out <= r_wrf;
          valid_out        <= 1'b1;
          writeEnable_out  <= r_we;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_execute.sv
// Self-checking bench for stage_execute: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_stage_execute;

  localparam int VS = 4;
  localparam int RS = 8;
  typedef logic [VS-1:0][RS-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [2:0]    aluOp;
  vec_t          srcA, srcB;
  logic [RS-1:0] imm, address;
  logic          writeEnable_in;
  logic [1:0]    writeRegFrom_in;
  logic          flush;
  logic          stall, valid_out, writeEnable_out;
  vec_t          aluResult, writeData;
  logic [RS-1:0] address_out, imm_out;
  logic [1:0]    writeRegFrom_out;

  int n_cmp = 0;
  int n_err = 0;

  vec_t          e_alu, e_wd;
  logic [RS-1:0] e_imm, e_addr;
  logic [1:0]    e_wrf;
  logic          e_valid, e_we, e_stall;

  stage_execute #(.vecSize(VS), .registerSize(RS)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .aluOp(aluOp),
    .srcA(srcA), .srcB(srcB), .imm(imm), .address(address),
    .writeEnable_in(writeEnable_in), .writeRegFrom_in(writeRegFrom_in),
    .flush(flush), .stall(stall), .valid_out(valid_out),
    .aluResult(aluResult), .writeData(writeData), .address_out(address_out),
    .imm_out(imm_out), .writeEnable_out(writeEnable_out),
    .writeRegFrom_out(writeRegFrom_out)
  );

  always #5 clk = ~clk;

  // Lane-wise reference computed with plain integer arithmetic, reduced mod 2^RS.
  function automatic vec_t model(input int op, input vec_t a, input vec_t b);
    vec_t res;
    for (int i = 0; i < VS; i++) begin
      int x, y, r;
      x = int'(a[i]);
      y = int'(b[i]);
      case (op)
        0: r = x + y;
        1: r = x - y;
        2: r = x & y;
        3: r = x | y;
        4: r = x ^ y;
        5: r = x << (y % RS);
        6: r = x >> (y % RS);
        default: r = x * y;
      endcase
      res[i] = RS'(r);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".aluResult"}, 64'(aluResult), 64'(e_alu));
    check({tag, ".writeData"}, 64'(writeData), 64'(e_wd));
    check({tag, ".imm_out"}, 64'(imm_out), 64'(e_imm));
    check({tag, ".address_out"}, 64'(address_out), 64'(e_addr));
    check({tag, ".writeRegFrom_out"}, 64'(writeRegFrom_out), 64'(e_wrf));
    check({tag, ".valid_out"}, 64'(valid_out), 64'(e_valid));
    check({tag, ".writeEnable_out"}, 64'(writeEnable_out), 64'(e_we));
    check({tag, ".stall"}, 64'(stall), 64'(e_stall));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int op, input vec_t a, input vec_t b,
                       input logic [RS-1:0] im, input logic [RS-1:0] ad,
                       input logic we, input logic [1:0] wrf);
    valid_in = v; aluOp = 3'(op); srcA = a; srcB = b;
    imm = im; address = ad; writeEnable_in = we; writeRegFrom_in = wrf;
  endtask

  task automatic expect_load(input int op, input vec_t a, input vec_t b,
                             input logic [RS-1:0] im, input logic [RS-1:0] ad,
                             input logic we, input logic [1:0] wrf);
    e_alu = model(op, a, b); e_wd = b; e_imm = im; e_addr = ad; e_wrf = wrf;
    e_valid = 1'b1; e_we = we; e_stall = 1'b0;
  endtask

  task automatic do_alu(input string tag, input int op, input vec_t a, input vec_t b,
                        input logic [RS-1:0] im, input logic [RS-1:0] ad,
                        input logic we, input logic [1:0] wrf);
    drive(1'b1, op, a, b, im, ad, we, wrf);
    tick();
    expect_load(op, a, b, im, ad, we, wrf);
    check_all(tag);
    valid_in = 1'b0;
  endtask

  // Multiply: accept edge, then VS busy edges; optionally an ADD is presented
  // right after acceptance and must only be taken once the stage is idle again.
  task automatic do_mul(input string tag, input vec_t a, input vec_t b,
                        input logic [RS-1:0] im, input logic [RS-1:0] ad,
                        input logic we, input logic [1:0] wrf, input bit next_add);
    vec_t na, nb;
    na = vec_t'({8'h11, 8'h22, 8'h33, 8'hF0});
    nb = vec_t'({8'h01, 8'h02, 8'h03, 8'h20});
    drive(1'b1, 7, a, b, im, ad, we, wrf);
    tick();
    if (next_add) drive(1'b1, 0, na, nb, 8'h5A, 8'hA5, 1'b1, 2'd2);
    else valid_in = 1'b0;
    e_valid = 1'b0; e_we = 1'b0; e_stall = 1'b1;
    check_all({tag, ".accept"});
    for (int k = 1; k < VS; k++) begin
      tick();
      check_all({tag, ".busy"});
    end
    tick();
    expect_load(7, a, b, im, ad, we, wrf);
    check_all({tag, ".done"});
    if (next_add) begin
      tick();
      expect_load(0, na, nb, 8'h5A, 8'hA5, 1'b1, 2'd2);
      check_all({tag, ".held_add"});
      valid_in = 1'b0;
    end
  endtask

  initial begin
    vec_t a, b;
    int op;

    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 0, '0, '0, '0, '0, 1'b0, 2'd0);
    e_alu = '0; e_wd = '0; e_imm = '0; e_addr = '0; e_wrf = '0;
    e_valid = 1'b0; e_we = 1'b0; e_stall = 1'b0;
    #3;
    check_all("reset");
    #8 reset = 1'b1;

    // ADD with wrap on lane 0 (lane 0 is the least significant byte)
    a = vec_t'({8'h7F, 8'h10, 8'h01, 8'hFF});
    b = vec_t'({8'h01, 8'h10, 8'h01, 8'h01});
    do_alu("add_dir", 0, a, b, 8'h3C, 8'hC3, 1'b1, 2'd1);
    check("add_dir.value", 64'(aluResult), 64'(32'h80_20_02_00));

    tick();
    e_valid = 1'b0; e_we = 1'b0;
    check_all("idle_hold");

    a = vec_t'({8'h81, 8'h81, 8'h81, 8'h81});
    b = vec_t'({8'd9, 8'd7, 8'd1, 8'd0});
    do_alu("sll_dir", 5, a, b, 8'h01, 8'h02, 1'b0, 2'd0);
    check("sll_dir.value", 64'(aluResult), 64'(32'h02_80_02_81));
    do_alu("srl_dir", 6, a, b, 8'h03, 8'h04, 1'b1, 2'd2);
    check("srl_dir.value", 64'(aluResult), 64'(32'h40_01_40_81));

    a = vec_t'({8'd0, 8'd255, 8'd16, 8'd3});
    b = vec_t'({8'd9, 8'd255, 8'd16, 8'd5});
    do_mul("mul_dir", a, b, 8'h77, 8'h88, 1'b1, 2'd1, 1'b0);
    check("mul_dir.value", 64'(aluResult), 64'(32'h00_01_00_0F));

    do_mul("mul_hold", a, b, 8'h12, 8'h34, 1'b0, 2'd0, 1'b1);

    // Randomized traffic across all eight operations
    for (int n = 0; n < 24; n++) begin
      a = vec_t'($urandom);
      b = vec_t'($urandom);
      op = int'($urandom_range(0, 7));
      if (op == 7)
        do_mul("rnd_mul", a, b, 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 1'b0);
      else
        do_alu("rnd_alu", op, a, b, 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        e_valid = 1'b0; e_we = 1'b0;
        check_all("rnd_idle");
      end
    end

    // Flush in the second busy cycle of a multiply
    a = vec_t'({8'd2, 8'd3, 8'd4, 8'd5});
    drive(1'b1, 7, a, a, 8'hEE, 8'hDD, 1'b1, 2'd1);
    tick();
    valid_in = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    e_valid = 1'b0; e_we = 1'b0; e_stall = 1'b0;
    check_all("flush_busy");
    tick();
    check_all("flush_after");

    // Flush beats a valid ALU instruction in IDLE
    drive(1'b1, 4, a, a, 8'h99, 8'h98, 1'b1, 2'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0; valid_in = 1'b0;
    check_all("flush_idle");

    // Asynchronous reset while the multiply counter sits at 2
    drive(1'b1, 7, a, a, 8'hAB, 8'hCD, 1'b1, 2'd1);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    e_alu = '0; e_wd = '0; e_imm = '0; e_addr = '0; e_wrf = '0;
    e_valid = 1'b0; e_we = 1'b0; e_stall = 1'b0;
    check_all("reset_mid_mul");
    #2 reset = 1'b1;
    b = vec_t'({8'h01, 8'h01, 8'h01, 8'h01});
    do_alu("add_after_reset", 0, a, b, 8'h42, 8'h24, 1'b1, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
